// File: rtl/aes_pkg.sv
// AES shared package: FSM states, block bundle, lane sizing
// and GF(2^8) helpers for the byte-substitution datapath.
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic         inv;
    logic [127:0] data;
  } sb_blk_t;

  function automatic bit lanes_ok(input int l);
    return l == 1 || l == 2 || l == 4 ||
           l == 8 || l == 16;
  endfunction

  function automatic int beats_of(input int l);
    return (l > 0) ? 16 / l : 1;
  endfunction

  function automatic logic [7:0] xtime(
    input logic [7:0] a
  );
    return {a[6:0], 1'b0} ^
           (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse; 0 maps to 0
  function automatic logic [7:0] gf_inv(
    input logic [7:0] a
  );
    logic [7:0] s;
    logic [7:0] r;
    s = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(
    input logic [7:0] b,
    input int         n
  );
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  function automatic logic [7:0] fwd_affine(
    input logic [7:0] b
  );
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^
           rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_affine(
    input logic [7:0] b
  );
    return rotl(b, 1) ^ rotl(b, 3) ^
           rotl(b, 6) ^ 8'h05;
  endfunction

endpackage

// File: rtl/inv_sbox.sv
// AES inverse S-box: inverse affine map followed
// by the field inverse.
module inv_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);

  assign y = gf_inv(inv_affine(a));

endmodule

// File: rtl/sbox.sv
// AES forward S-box: field inverse followed by
// the forward affine map.
module sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);

  assign y = fwd_affine(gf_inv(a));

endmodule

// File: rtl/sbox_lane.sv
// One substitution lane: forward and inverse
// S-boxes side by side, selected by inv.
module sbox_lane (
  input  logic [7:0] a,
  input  logic       inv,
  output logic [7:0] y
);

  logic [7:0] f;
  logic [7:0] r;

  sbox u_fwd (
    .a (a),
    .y (f)
  );

  inv_sbox u_inv (
    .a (a),
    .y (r)
  );

  assign y = inv ? r : f;

endmodule

// File: rtl/sub_bytes_engine.sv
// Sequential AES SubBytes/InvSubBytes engine:
// LANES S-boxes walk a 128-bit state MSB group first.
module sub_bytes_engine
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int BEATS = beats_of(LANES);
  localparam int CW =
    (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int W = 8 * LANES;

  if (!lanes_ok(LANES)) begin : g_bad
    $error("sub_bytes_engine: bad LANES %0d",
           LANES);
  end

  state_t        state;
  state_t        nxt;
  sb_blk_t       blk;
  logic [127:0]  res;
  logic [CW-1:0] cnt;
  logic [CW-1:0] grp;
  logic          armed;
  logic          accept;
  logic          last;
  logic [W-1:0]  lin;
  logic [W-1:0]  lout;

  assign accept   = in_valid & in_ready;
  assign grp      = CW'(BEATS - 1) - cnt;
  assign last     = (cnt == CW'(BEATS - 1));
  assign lin      = blk.data[grp*W +: W];
  assign out_data = res;

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    sbox_lane u_lane (
      .a   (lin[8*j +: 8]),
      .inv (blk.inv),
      .y   (lout[8*j +: 8])
    );
  end

  // Hold off in_ready until the first edge out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) armed <= 1'b0;
    else        armed <= 1'b1;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= nxt;
  end

  // Next-state: DONE can hand straight to RUN
  always_comb begin
    nxt = state;
    unique case (1'b1)
      (state == ST_IDLE):
        if (accept) nxt = ST_RUN;
      (state == ST_RUN):
        if (last) nxt = ST_DONE;
      (state == ST_DONE):
        if (out_ready)
          nxt = accept ? ST_RUN : ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end

  // Handshake and status outputs
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (1'b1)
      (state == ST_IDLE): in_ready = armed;
      (state == ST_RUN):  busy = 1'b1;
      (state == ST_DONE): begin
        out_valid = 1'b1;
        busy      = 1'b1;
        in_ready  = out_ready;
      end
      default: ;
    endcase
  end

  // Latch block at accept, write one group per beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk <= '0;
      res <= '0;
      cnt <= '0;
    end else if (accept) begin
      blk.data <= in_data;
      blk.inv  <= in_inv;
      cnt      <= '0;
    end else if (state == ST_RUN) begin
      res[grp*W +: W] <= lout;
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: doc/sub_bytes_engine.md
Name: sub_bytes_engine

Overview:
- Parametrised, sequential AES byte-substitution unit replacing the fixed 16-lane combinational inverse substitution.
- Supports forward (SubBytes) and inverse (InvSubBytes) modes, selected per transaction.
- Processes one 128-bit state over 16/LANES cycles, trading S-box area for latency.
- Sits between the round-key/shift stages of the AES datapath and uses valid/ready handshakes on both sides.

Parameters:
- LANES, 4: S-box lanes per cycle; legal values 1, 2, 4, 8, 16; any other value is an elaboration error.
- BEATS, 16/LANES: derived; cycles per block; not overridable.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input block valid.
- in_ready  output  1  engine can accept a block.
- in_data  input  128  state in; byte 15 = bits 127:120, byte 0 = bits 7:0.
- in_inv  input  1  0 = forward S-box, 1 = inverse S-box; sampled at accept.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  128  substituted state, same byte order as in_data.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (async assert, sync release) returns the engine to IDLE and sets:
  - out_valid=0, busy=0, out_data=0, beat counter=0, latched mode=0;
  - in_ready=1 after the first clock edge with rst_n high;
  - a reset mid-RUN or in DONE discards the block with no output.
- FSM states IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - Accept occurs when in_valid and in_ready are both high.
  - On accept, latch in_data into the source register, latch in_inv, clear the counter, and go to RUN.
- RUN:
  - Each cycle, beat k (0..BEATS-1) substitutes bytes 15-k*LANES down to 16-(k+1)*LANES, MSB group first.
  - Results are written into the result register at the same byte positions.
  - The counter increments each beat; after beat BEATS-1, go to DONE.
  - in_ready=0 throughout.
- DONE:
  - out_valid=1; out_data is the full result and is held stable while out_ready=0.
  - On out_valid and out_ready, the result is consumed.
  - in_ready = out_ready in DONE, so a new block can be accepted in the same cycle as the result is consumed. That block goes straight to RUN; otherwise the engine goes to IDLE.
- Latency:
  - Accept cycle = cycle 0; RUN occupies cycles 1..BEATS.
  - out_valid is first high in cycle BEATS+1 (LANES=16: cycle 2; LANES=1: cycle 17).
  - Throughput: one block per BEATS+1 cycles with back-to-back handshakes.
- Mode:
  - The latched mode applies to every beat of the block.
  - in_inv changes outside the accept cycle are ignored.
- The S-box lanes are combinational; the only registers are the source, result, counter, mode and FSM.
- in_data changes after accept have no effect.
- out_valid never deasserts without a handshake, except on reset.

Decomposition:
- Shared package (aes_pkg):
  - state encoding constants ST_IDLE, ST_RUN, ST_DONE;
  - the BEATS computation function;
  - the legal-LANES check.
- Sub-module sbox_lane:
  - 8-bit in, 8-bit out, 1-bit inv select;
  - instantiates the team's existing sbox and inv_sbox and muxes their outputs.
- LANES copies of sbox_lane are generated in the engine.

Test Plan:
- Forward, LANES=4: in_data=0x00112233445566778899aabbccddeeff, in_inv=0 -> out_data=0x638293c31bfc33f5c4eeacea4bc12816; out_valid first high in cycle 5.
- Inverse, LANES=4: in_data=0x638293c31bfc33f5c4eeacea4bc12816, in_inv=1 -> out_data=0x00112233445566778899aabbccddeeff.
- Sweep LANES=1,2,8,16 with the forward vector -> identical out_data; out_valid first high in cycle 17, 9, 3, 2 respectively.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_data stable, in_ready=0 throughout; then raise out_ready together with in_valid and the inverse vector -> second block accepted in that cycle, correct inverse result BEATS+1 cycles later.
- Reset mid-RUN: assert rst_n=0 at beat 2 (LANES=4) -> out_valid=0, out_data=0, busy=0 immediately; after release, a new block completes correctly with no stale bytes.
- Mode isolation: accept with in_inv=0, toggle in_inv every cycle during RUN -> output equals the pure forward result.
